// File: rtl/mult_iter_pkg.sv
// Shared types, constants and helpers for the iterative multiplier.
package mult_pkg;

   // Control FSM states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Ceiling log2, never smaller than 1 so it can size a register
   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      if (r < 1) begin
         r = 1;
      end
      return r;
   endfunction

   // Default configuration: 12-bit operands, one multiplier bit per cycle
   localparam int DEF_M      = 12;
   localparam int DEF_UNROLL = 1;
   localparam int DEF_K      = DEF_M / DEF_UNROLL;
   localparam int DEF_CNT_W  = clog2(DEF_K + 1);

endpackage

// File: rtl/mult_iter_pp_step.sv
// One partial-product step: psum_out = psum_in + (a_mag * b_slice) << shift.
module mult_pp_step
   import mult_pkg::*;
#(
   parameter int M      = 12,
   parameter int UNROLL = 1,
   parameter int SH_W   = 5
) (
   input  logic [2*M-1:0]    psum_in,
   input  logic [M-1:0]      a_mag,
   input  logic [UNROLL-1:0] b_slice,
   input  logic [SH_W-1:0]   shift,
   output logic [2*M-1:0]    psum_out
);

   logic [2*M-1:0] a_ext_s;
   logic [2*M-1:0] b_ext_s;
   logic [2*M-1:0] prod_s;

   // Widen both operands to the product width, multiply the slice and align it
   always_comb begin
      a_ext_s  = {{M{1'b0}}, a_mag};
      b_ext_s  = {{(2*M-UNROLL){1'b0}}, b_slice};
      prod_s   = a_ext_s * b_ext_s;
      psum_out = psum_in + (prod_s << shift);
   end

endmodule

// File: rtl/mult_iter.sv
// Iterative signed/unsigned multiplier with optional accumulate and
// valid/ready handshakes on both sides. Operands are reduced to magnitudes,
// multiplied UNROLL multiplier bits per cycle, and the sign is re-applied
// when the result is registered.
module mult_iter
   import mult_pkg::*;
#(
   parameter int M      = 12,
   parameter int UNROLL = 1,
   parameter int G      = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [M-1:0]     a,
   input  logic [M-1:0]     b,
   input  logic             signed_mode,
   input  logic             acc_en,
   input  logic             acc_clr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2*M-1:0]   mult,
   output logic [2*M+G-1:0] acc
);

   localparam int K     = M / UNROLL;
   localparam int CNT_W = clog2(K + 1);
   localparam int SH_W  = clog2(2 * M);
   localparam int P_W   = 2 * M;
   localparam int A_W   = 2 * M + G;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [M-1:0]     a_mag_q, a_mag_d;
   logic [M-1:0]     b_sh_q, b_sh_d;
   logic             sign_q, sign_d;
   logic             smode_q, smode_d;
   logic             acc_en_q, acc_en_d;
   logic             acc_clr_q, acc_clr_d;
   logic [P_W-1:0]   psum_q, psum_d;
   logic [P_W-1:0]   mult_q, mult_d;
   logic [A_W-1:0]   acc_q, acc_d;
   logic             out_valid_q, out_valid_d;
   logic             in_ready_q, in_ready_d;

   logic [M-1:0]     a_mag_s;
   logic [M-1:0]     b_mag_s;
   logic [SH_W-1:0]  shamt_s;
   logic [P_W-1:0]   step_s;
   logic [P_W-1:0]   mult_res_s;
   logic [A_W-1:0]   mult_ext_s;
   logic [A_W-1:0]   acc_base_s;

   // Operand magnitudes; -2^(M-1) maps onto itself, which is exact as unsigned
   always_comb begin
      if (signed_mode && a[M-1]) begin
         a_mag_s = ~a + {{(M-1){1'b0}}, 1'b1};
      end else begin
         a_mag_s = a;
      end
      if (signed_mode && b[M-1]) begin
         b_mag_s = ~b + {{(M-1){1'b0}}, 1'b1};
      end else begin
         b_mag_s = b;
      end
   end

   // Result formatting: re-apply the sign, then extend for the accumulator
   always_comb begin
      shamt_s = SH_W'(cnt_q) * SH_W'(UNROLL);
      if (sign_q) begin
         mult_res_s = ~psum_q + {{(P_W-1){1'b0}}, 1'b1};
      end else begin
         mult_res_s = psum_q;
      end
      if (smode_q) begin
         mult_ext_s = {{G{mult_res_s[P_W-1]}}, mult_res_s};
      end else begin
         mult_ext_s = {{G{1'b0}}, mult_res_s};
      end
      if (acc_clr_q) begin
         acc_base_s = {A_W{1'b0}};
      end else begin
         acc_base_s = acc_q;
      end
   end

   mult_pp_step #(
      .M      (M),
      .UNROLL (UNROLL),
      .SH_W   (SH_W)
   ) u_step (
      .psum_in  (psum_q),
      .a_mag    (a_mag_q),
      .b_slice  (b_sh_q[UNROLL-1:0]),
      .shift    (shamt_s),
      .psum_out (step_s)
   );

   // FSM next-state, datapath updates and registered-output next values
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      a_mag_d     = a_mag_q;
      b_sh_d      = b_sh_q;
      sign_d      = sign_q;
      smode_d     = smode_q;
      acc_en_d    = acc_en_q;
      acc_clr_d   = acc_clr_q;
      psum_d      = psum_q;
      mult_d      = mult_q;
      acc_d       = acc_q;
      out_valid_d = out_valid_q;
      case (state_q)
         IDLE: begin
            if (in_valid && in_ready_q) begin
               a_mag_d   = a_mag_s;
               b_sh_d    = b_mag_s;
               sign_d    = (a[M-1] ^ b[M-1]) & signed_mode;
               smode_d   = signed_mode;
               acc_en_d  = acc_en;
               acc_clr_d = acc_clr;
               psum_d    = {P_W{1'b0}};
               cnt_d     = {CNT_W{1'b0}};
               state_d   = RUN;
            end else begin
               state_d   = IDLE;
            end
         end
         RUN: begin
            if (cnt_q == CNT_W'(K)) begin
               // All slices retired: publish the product and update acc once
               mult_d      = mult_res_s;
               out_valid_d = 1'b1;
               state_d     = DONE;
               if (acc_en_q) begin
                  acc_d = acc_base_s + mult_ext_s;
               end else begin
                  acc_d = acc_q;
               end
            end else begin
               psum_d = step_s;
               cnt_d  = cnt_q + CNT_W'(1);
               b_sh_d = b_sh_q >> UNROLL;
            end
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end else begin
               state_d     = DONE;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
         end
      endcase
      in_ready_d = (state_d == IDLE);
   end

   // State, work and result registers; reset aborts any pending operation
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= {CNT_W{1'b0}};
         a_mag_q     <= {M{1'b0}};
         b_sh_q      <= {M{1'b0}};
         sign_q      <= 1'b0;
         smode_q     <= 1'b0;
         acc_en_q    <= 1'b0;
         acc_clr_q   <= 1'b0;
         psum_q      <= {P_W{1'b0}};
         mult_q      <= {P_W{1'b0}};
         acc_q       <= {A_W{1'b0}};
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         a_mag_q     <= a_mag_d;
         b_sh_q      <= b_sh_d;
         sign_q      <= sign_d;
         smode_q     <= smode_d;
         acc_en_q    <= acc_en_d;
         acc_clr_q   <= acc_clr_d;
         psum_q      <= psum_d;
         mult_q      <= mult_d;
         acc_q       <= acc_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign mult      = mult_q;
   assign acc       = acc_q;

endmodule
